// File: rtl/wallace_mult_if.sv
// -----------------------------------------------------------------------------
// wallace_mult_if
//   Handshake bundle between an operand producer, the pipelined Wallace-tree
//   multiplier and the product consumer.
//
//   Signals:
//     in_valid  producer -> mult   operand pair and mode present
//     in_ready  mult -> producer   operands accepted on this edge if in_valid
//     x, y      producer -> mult   WIDTH-bit multiplicand / multiplier
//     is_signed producer -> mult   1 = two's-complement operands
//     out_valid mult -> consumer   z holds a completed product
//     out_ready consumer -> mult   consumer takes z on this edge
//     z         mult -> consumer   2*WIDTH-bit product
//     z_signed  mult -> consumer   is_signed of the transaction on z
//
//   Modports:
//     master  the producer/consumer side (testbench or surrounding datapath)
//     slave   the multiplier
// -----------------------------------------------------------------------------
interface wallace_mult_if #(
  parameter int WIDTH = 4
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic [WIDTH-1:0]     y;
  logic                 is_signed;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   z;
  logic                 z_signed;

  modport master (
    output in_valid,
    output x,
    output y,
    output is_signed,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  z,
    input  z_signed
  );

  modport slave (
    input  in_valid,
    input  x,
    input  y,
    input  is_signed,
    input  out_ready,
    output in_ready,
    output out_valid,
    output z,
    output z_signed
  );

endinterface

// File: rtl/wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// wallace_mult_pipe
//   WIDTH x WIDTH multiplier, unsigned or two's-complement signed per
//   transaction, built as a 3-stage registered pipeline with valid/ready
//   handshakes on both sides. One product per clock at full throughput.
//
//   S1  partial-product matrix (Baugh-Wooley terms in signed mode)
//   S2  Wallace reduction to two rows (sum row, carry row)
//   S3  carry-propagate add into z; this register drives the outputs
//
//   Ports:
//     clk   rising-edge clock
//     rst   asynchronous, active-high reset; empties the pipeline
//     bus   wallace_mult_if.slave (in_valid/in_ready/x/y/is_signed,
//           out_valid/out_ready/z/z_signed)
//
//   Parameters:
//     WIDTH operand width, 4..16; the product is 2*WIDTH bits.
// -----------------------------------------------------------------------------
module wallace_mult_pipe #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  wallace_mult_if.slave bus
);

  localparam int PW  = 2 * WIDTH;       // product width
  localparam int NPP = WIDTH * WIDTH;   // partial-product bits
  // Column storage height. The tallest column never exceeds WIDTH, and a
  // reduction layer never makes a column taller, so PW is comfortably safe.
  localparam int COL_H = PW;
  // Layers needed: 4 for WIDTH=8, 6 for WIDTH=16. Extra passes are no-ops.
  localparam int MAX_LAYERS = 10;

  // ---------------------------------------------------------------------------
  // Wallace reduction of a partial-product matrix to two rows.
  // Bit pp[i*WIDTH+j] has weight 2^(i+j). In signed mode the two Baugh-Wooley
  // correction constants are added at columns WIDTH and PW-1. Column heights
  // depend only on WIDTH and sgn, so every loop collapses into a fixed adder
  // network; the int counters are bookkeeping, not hardware.
  // ---------------------------------------------------------------------------
  function automatic logic [2*PW-1:0] wallace_rows(
    input logic [NPP-1:0] pp,
    input logic           sgn
  );
    logic [COL_H-1:0] col  [PW];
    int               cnt  [PW];
    logic [COL_H-1:0] nxt  [PW];
    int               ncnt [PW];
    logic [PW-1:0]    row_s;
    logic [PW-1:0]    row_c;
    int               max_h;
    logic             a;
    logic             b;
    logic             ci;

    // NOTE: blocking assignments inside combinational code (functions,
    // always_comb) model wires evaluated in order; registers use <= instead.
    for (int c = 0; c < PW; c++) begin
      col[c] = '0;
      cnt[c] = 0;
    end

    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        col[i+j][cnt[i+j]] = pp[i*WIDTH+j];
        cnt[i+j]++;
      end
    end

    if (sgn) begin
      col[WIDTH][cnt[WIDTH]] = 1'b1;
      cnt[WIDTH]++;
      col[PW-1][cnt[PW-1]] = 1'b1;
      cnt[PW-1]++;
    end

    for (int l = 0; l < MAX_LAYERS; l++) begin
      max_h = 0;
      for (int c = 0; c < PW; c++) begin
        if (cnt[c] > max_h) max_h = cnt[c];
      end

      if (max_h > 2) begin
        for (int c = 0; c < PW; c++) begin
          nxt[c]  = '0;
          ncnt[c] = 0;
        end

        // Each column is cut into groups of three (full adder), a trailing
        // pair (half adder) or a single bit (passed through). Carries out of
        // the top column fall off: the product is truncated to PW bits.
        for (int c = 0; c < PW; c++) begin
          for (int g = 0; g < COL_H; g += 3) begin
            if (g + 2 < cnt[c]) begin
              a  = col[c][g];
              b  = col[c][g+1];
              ci = col[c][g+2];
              nxt[c][ncnt[c]] = a ^ b ^ ci;
              ncnt[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = (a & b) | (a & ci) | (b & ci);
                ncnt[c+1]++;
              end
            end else if (g + 1 < cnt[c]) begin
              a = col[c][g];
              b = col[c][g+1];
              nxt[c][ncnt[c]] = a ^ b;
              ncnt[c]++;
              if (c + 1 < PW) begin
                nxt[c+1][ncnt[c+1]] = a & b;
                ncnt[c+1]++;
              end
            end else if (g < cnt[c]) begin
              nxt[c][ncnt[c]] = col[c][g];
              ncnt[c]++;
            end
          end
        end

        col = nxt;
        cnt = ncnt;
      end
    end

    for (int c = 0; c < PW; c++) begin
      row_s[c] = (cnt[c] > 0) ? col[c][0] : 1'b0;
      row_c[c] = (cnt[c] > 1) ? col[c][1] : 1'b0;
    end

    return {row_c, row_s};
  endfunction

  // ---------------------------------------------------------------------------
  // Stall control. A stage loads when it is empty or its successor loads this
  // cycle; the chain starts at the consumer's out_ready, so in_ready is a
  // combinational function of out_ready through three stages.
  // ---------------------------------------------------------------------------
  logic v1;
  logic v2;
  logic v3;
  logic load1;
  logic load2;
  logic load3;

  assign load3        = ~v3 | bus.out_ready;
  assign load2        = ~v2 | load3;
  assign load1        = ~v1 | load2;
  assign bus.in_ready = load1;

  // ---------------------------------------------------------------------------
  // S1: partial-product matrix.
  // Signed mode inverts every term pairing one operand's MSB with a non-MSB
  // bit of the other; MSB*MSB stays positive.
  // ---------------------------------------------------------------------------
  logic [NPP-1:0] pp_next;
  logic [NPP-1:0] pp1;
  logic           s1;

  always_comb begin
    pp_next = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        pp_next[i*WIDTH+j] = bus.x[i] & bus.y[j];
        if (bus.is_signed && ((i == WIDTH - 1) != (j == WIDTH - 1))) begin
          pp_next[i*WIDTH+j] = ~(bus.x[i] & bus.y[j]);
        end
      end
    end
  end

  // NOTE: all pipeline registers, data included, clear asynchronously so the
  // outputs read z=0 / z_signed=0 during reset; the non-blocking <= makes
  // every stage sample its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1  <= 1'b0;
      pp1 <= '0;
      s1  <= 1'b0;
    end else if (load1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        pp1 <= pp_next;
        s1  <= bus.is_signed;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S2: Wallace tree, registered as two rows.
  // ---------------------------------------------------------------------------
  logic [2*PW-1:0] rows_next;
  logic [PW-1:0]   sum2;
  logic [PW-1:0]   carry2;
  logic            s2;

  assign rows_next = wallace_rows(pp1, s1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2     <= 1'b0;
      sum2   <= '0;
      carry2 <= '0;
      s2     <= 1'b0;
    end else if (load2) begin
      v2 <= v1;
      if (v1) begin
        sum2   <= rows_next[PW-1:0];
        carry2 <= rows_next[2*PW-1:PW];
        s2     <= s1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // S3: final carry-propagate add; the PW-bit sum drops the overflow carry.
  // The register only changes on a load, so z and z_signed hold while the
  // consumer stalls.
  // ---------------------------------------------------------------------------
  logic [PW-1:0] z3;
  logic          s3;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v3 <= 1'b0;
      z3 <= '0;
      s3 <= 1'b0;
    end else if (load3) begin
      v3 <= v2;
      if (v2) begin
        z3 <= sum2 + carry2;
        s3 <= s2;
      end
    end
  end

  assign bus.out_valid = v3;
  assign bus.z         = z3;
  assign bus.z_signed  = s3;

endmodule

// File: tb/tb_wallace_mult_pipe.sv
// -----------------------------------------------------------------------------
// tb_wallace_mult_pipe
//   Directed checks of wallace_mult_pipe at WIDTH 4, 8 and 16, plus a random
//   stream at WIDTH 8 scored against an arithmetic model. Inputs change and
//   outputs are sampled on the falling edge, away from the active edge.
// -----------------------------------------------------------------------------
module tb_wallace_mult_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  wallace_mult_if #(.WIDTH(4))  bus4 ();
  wallace_mult_if #(.WIDTH(8))  bus8 ();
  wallace_mult_if #(.WIDTH(16)) bus16 ();

  wallace_mult_pipe #(.WIDTH(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4.slave));
  wallace_mult_pipe #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
  wallace_mult_pipe #(.WIDTH(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive4(input logic v, input logic [3:0] a, input logic [3:0] b, input logic s);
    bus4.in_valid  = v;
    bus4.x         = a;
    bus4.y         = b;
    bus4.is_signed = s;
  endtask

  task automatic drive8(input logic v, input logic [7:0] a, input logic [7:0] b, input logic s);
    bus8.in_valid  = v;
    bus8.x         = a;
    bus8.y         = b;
    bus8.is_signed = s;
  endtask

  task automatic drive16(input logic v, input logic [15:0] a, input logic [15:0] b, input logic s);
    bus16.in_valid  = v;
    bus16.x         = a;
    bus16.y         = b;
    bus16.is_signed = s;
  endtask

  // Reference product for WIDTH=8: {mode, 16-bit product}.
  function automatic logic [16:0] model8(input logic [7:0] a, input logic [7:0] b, input logic s);
    longint pa;
    longint pb;
    longint p;
    pa = s ? longint'($signed(a)) : longint'(a);
    pb = s ? longint'($signed(b)) : longint'(b);
    p  = pa * pb;
    return {s, p[15:0]};
  endfunction

  // Absolute time bound; the loops below are cycle-bounded as well.
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [16:0] exp_q[$];
    logic [16:0] held;
    logic        was_stalled;
    logic        acc;
    logic        xfer;
    int          sent;
    int          cycles;

    drive4(0, '0, '0, 0);
    drive8(0, '0, '0, 0);
    drive16(0, '0, '0, 0);
    bus4.out_ready  = 1'b0;
    bus8.out_ready  = 1'b0;
    bus16.out_ready = 1'b0;
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // ---- Reset state --------------------------------------------------------
    check("rst_in_ready", bus4.in_ready, 1);
    check("rst_out_valid", bus4.out_valid, 0);
    check("rst_z", bus4.z, 0);
    check("rst_z_signed", bus4.z_signed, 0);
    rst = 1'b0;

    // ---- W4 unsigned 15x15, accepted on the first edge after reset ---------
    bus4.out_ready = 1'b1;
    drive4(1, 4'd15, 4'd15, 0);
    tick();                                   // acceptance edge
    drive4(0, '0, '0, 0);
    check("t1_ov_edge1", bus4.out_valid, 0);
    tick();
    check("t1_ov_edge2", bus4.out_valid, 0);
    tick();                                   // third register loaded
    check("t1_ov_edge3", bus4.out_valid, 1);
    check("t1_z", bus4.z, 8'hE1);
    check("t1_z_signed", bus4.z_signed, 0);
    tick();
    check("t1_ov_after", bus4.out_valid, 0);

    // ---- W4 signed, three back-to-back -------------------------------------
    drive4(1, 4'b1000, 4'b1000, 1);
    tick();
    drive4(1, 4'b1000, 4'b0111, 1);
    tick();
    drive4(1, 4'b1111, 4'b0001, 1);
    tick();
    drive4(0, '0, '0, 0);
    check("t2_ov0", bus4.out_valid, 1);
    check("t2_z0", bus4.z, 8'h40);
    check("t2_zs0", bus4.z_signed, 1);
    tick();
    check("t2_ov1", bus4.out_valid, 1);
    check("t2_z1", bus4.z, 8'hC8);
    tick();
    check("t2_ov2", bus4.out_valid, 1);
    check("t2_z2", bus4.z, 8'hFF);
    check("t2_zs2", bus4.z_signed, 1);
    tick();
    check("t2_ov_after", bus4.out_valid, 0);

    // ---- W4 backpressure: capacity 3, hold, drain in order -----------------
    bus4.out_ready = 1'b0;
    drive4(1, 4'd1, 4'd2, 0);
    tick();
    drive4(1, 4'd3, 4'd4, 0);
    tick();
    drive4(1, 4'd5, 4'd6, 0);
    tick();
    drive4(1, 4'd7, 4'd8, 0);                 // fourth, must be refused
    #1;
    check("t3_full_in_ready", bus4.in_ready, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check("t3_hold_in_ready", bus4.in_ready, 0);
      check("t3_hold_ov", bus4.out_valid, 1);
      check("t3_hold_z", bus4.z, 8'd2);
    end
    bus4.out_ready = 1'b1;
    #1;
    check("t3_release_in_ready", bus4.in_ready, 1);
    tick();                                   // release edge: 1x2 out, 7x8 in
    drive4(0, '0, '0, 0);
    check("t3_d1_ov", bus4.out_valid, 1);
    check("t3_d1_z", bus4.z, 8'd12);
    tick();
    check("t3_d2_z", bus4.z, 8'd30);
    tick();
    check("t3_d3_ov", bus4.out_valid, 1);
    check("t3_d3_z", bus4.z, 8'd56);
    tick();
    check("t3_empty_ov", bus4.out_valid, 0);

    // ---- Asynchronous reset with two transactions in flight ----------------
    bus4.out_ready = 1'b0;
    drive4(1, 4'd9, 4'd9, 0);
    tick();
    drive4(1, 4'd2, 4'd3, 1);
    tick();
    drive4(0, '0, '0, 0);
    tick();
    check("t4_pre_z", bus4.z, 8'd81);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("t4_rst_ov", bus4.out_valid, 0);
    check("t4_rst_z", bus4.z, 0);
    check("t4_rst_zs", bus4.z_signed, 0);
    check("t4_rst_in_ready", bus4.in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    bus4.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("t4_no_stale_ov", bus4.out_valid, 0);
    end
    drive4(1, 4'd3, 4'd5, 0);
    tick();
    drive4(0, '0, '0, 0);
    tick();
    tick();
    check("t4_new_ov", bus4.out_valid, 1);
    check("t4_new_z", bus4.z, 8'd15);
    check("t4_new_zs", bus4.z_signed, 0);

    // ---- W16 extremes -------------------------------------------------------
    bus16.out_ready = 1'b1;
    drive16(1, 16'h8000, 16'h8000, 1);
    tick();
    drive16(1, 16'hFFFF, 16'hFFFF, 0);
    tick();
    drive16(0, '0, '0, 0);
    tick();
    check("w16_signed_z", bus16.z, 32'h4000_0000);
    check("w16_signed_zs", bus16.z_signed, 1);
    tick();
    check("w16_unsigned_z", bus16.z, 32'hFFFE_0001);
    check("w16_unsigned_zs", bus16.z_signed, 0);

    // ---- W8 alternating modes on 0xFF x 0xFF -------------------------------
    bus8.out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) drive8(1, 8'hFF, 8'hFF, k[0]);
      else       drive8(0, '0, '0, 0);
      tick();
      if (k >= 2) begin
        check("w8_alt_ov", bus8.out_valid, 1);
        check("w8_alt_z", {bus8.z_signed, bus8.z}, (k % 2 == 1) ? 17'h1_0001 : 17'h0_FE01);
      end
    end
    tick();
    check("w8_alt_empty", bus8.out_valid, 0);

    // ---- W8 random stream with random backpressure -------------------------
    sent        = 0;
    cycles      = 0;
    was_stalled = 1'b0;
    held        = '0;
    while ((sent < 10000 || exp_q.size() > 0) && cycles < 60000) begin
      if (!bus8.in_valid && sent < 10000 && $urandom_range(0, 3) != 0) begin
        drive8(1, 8'($urandom), 8'($urandom), 1'($urandom));
      end
      bus8.out_ready = 1'($urandom);
      #1;
      if (was_stalled) begin
        check("rnd_hold_ov", bus8.out_valid, 1);
        check("rnd_hold_z", {bus8.z_signed, bus8.z}, held);
      end
      acc  = bus8.in_valid & bus8.in_ready;
      xfer = bus8.out_valid & bus8.out_ready;
      was_stalled = bus8.out_valid & ~bus8.out_ready;
      held        = {bus8.z_signed, bus8.z};
      if (xfer) begin
        if (exp_q.size() == 0) check("rnd_extra_out", exp_q.size(), 1);
        else                   check("rnd_z", {bus8.z_signed, bus8.z}, exp_q.pop_front());
      end
      if (acc) begin
        exp_q.push_back(model8(bus8.x, bus8.y, bus8.is_signed));
        sent++;
      end
      tick();
      cycles++;
      if (acc) bus8.in_valid = 1'b0;
    end
    check("rnd_sent", sent, 10000);
    check("rnd_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
